// File: rtl/cc_bus_scheduler.sv
// cc_bus_scheduler: two-source bus arbiter between a register source and a
// control source. The winner owns the bus for a bounded burst, its code is
// latched for the whole ownership, and ties alternate between the sources.
// Every output is taken straight from a flop so the bus mux sees clean signals.

module cc_bus_scheduler #(
    parameter int DATAWIDTH_MUX_SELECTION_REG     = 5,
    parameter int DATAWIDTH_MUX_SELECTION_CONTROL = 6,
    // Legal range 1..15 so the 4-bit burst counter never wraps.
    parameter int MAX_BURST                       = 4
) (
    input  logic                                       CC_BUS_SCHEDULER_CLOCK_50,
    input  logic                                       CC_BUS_SCHEDULER_RESET_InLow,
    input  logic                                       CC_BUS_SCHEDULER_regReq_In,
    input  logic [DATAWIDTH_MUX_SELECTION_REG-1:0]     CC_BUS_SCHEDULER_regCode_InBUS,
    input  logic                                       CC_BUS_SCHEDULER_ctrlReq_In,
    input  logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] CC_BUS_SCHEDULER_ctrlCode_InBUS,
    output logic                                       CC_BUS_SCHEDULER_regGrant_Out,
    output logic                                       CC_BUS_SCHEDULER_ctrlGrant_Out,
    output logic                                       CC_BUS_SCHEDULER_selector_Out,
    output logic [DATAWIDTH_MUX_SELECTION_REG-1:0]     CC_BUS_SCHEDULER_registro_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0] CC_BUS_SCHEDULER_control_OutBUS,
    output logic                                       CC_BUS_SCHEDULER_valid_Out,
    output logic                                       CC_BUS_SCHEDULER_codeError_Out
);

    localparam int RW = DATAWIDTH_MUX_SELECTION_REG;
    localparam int CW = DATAWIDTH_MUX_SELECTION_CONTROL;

    // Burst limit in the counter's own width.
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    // Highest legal code value on either code bus.
    localparam logic [31:0] CODE_LEGAL_MAX = 32'd11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REG_OWN  = 2'd1,
        CTRL_OWN = 2'd2
    } state_t;

    state_t          state_q,       state_d;
    logic [3:0]      count_q,       count_d;
    // 1 = the register source owned the bus most recently, 0 = control source.
    logic            lastOwnerReg_q, lastOwnerReg_d;

    logic            regGrant_q,    regGrant_d;
    logic            ctrlGrant_q,   ctrlGrant_d;
    logic            selector_q,    selector_d;
    logic [RW-1:0]   regCodeOut_q,  regCodeOut_d;
    logic [CW-1:0]   ctrlCodeOut_q, ctrlCodeOut_d;
    logic            valid_q,       valid_d;
    logic            codeError_q,   codeError_d;

    logic            pickReg;
    logic            pickCtrl;
    logic            regCodeBad;
    logic            ctrlCodeBad;
    logic            regRelease;
    logic            ctrlRelease;

    // Widened code comparison so the error check works for any bus width.
    always_comb begin
        regCodeBad  = (32'(CC_BUS_SCHEDULER_regCode_InBUS)  > CODE_LEGAL_MAX);
        ctrlCodeBad = (32'(CC_BUS_SCHEDULER_ctrlCode_InBUS) > CODE_LEGAL_MAX);
    end

    // Idle arbitration: a lone requester wins; on a tie the source that did not own last wins.
    always_comb begin
        pickReg  = CC_BUS_SCHEDULER_regReq_In &&
                   (!CC_BUS_SCHEDULER_ctrlReq_In || !lastOwnerReg_q);
        pickCtrl = CC_BUS_SCHEDULER_ctrlReq_In && !pickReg;
    end

    // An owner lets go when it drops its request or has used its full burst.
    always_comb begin
        regRelease  = !CC_BUS_SCHEDULER_regReq_In  || (count_q == BURST_LIMIT);
        ctrlRelease = !CC_BUS_SCHEDULER_ctrlReq_In || (count_q == BURST_LIMIT);
    end

    // Next-state and next-output logic; outputs fall back to the idle picture unless a branch keeps ownership.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        lastOwnerReg_d = lastOwnerReg_q;
        regGrant_d     = 1'b0;
        ctrlGrant_d    = 1'b0;
        valid_d        = 1'b0;
        codeError_d    = 1'b0;
        selector_d     = selector_q;
        regCodeOut_d   = '0;
        ctrlCodeOut_d  = '0;

        unique case (state_q)
            IDLE: begin
                count_d = 4'd0;
                if (pickReg) begin
                    state_d      = REG_OWN;
                    count_d      = 4'd1;
                    regGrant_d   = 1'b1;
                    valid_d      = 1'b1;
                    selector_d   = 1'b1;
                    regCodeOut_d = CC_BUS_SCHEDULER_regCode_InBUS;
                    codeError_d  = regCodeBad;
                end else if (pickCtrl) begin
                    state_d       = CTRL_OWN;
                    count_d       = 4'd1;
                    ctrlGrant_d   = 1'b1;
                    valid_d       = 1'b1;
                    selector_d    = 1'b0;
                    ctrlCodeOut_d = CC_BUS_SCHEDULER_ctrlCode_InBUS;
                    codeError_d   = ctrlCodeBad;
                end
            end

            REG_OWN: begin
                if (regRelease) begin
                    state_d        = IDLE;
                    count_d        = 4'd0;
                    lastOwnerReg_d = 1'b1;
                end else begin
                    count_d      = count_q + 4'd1;
                    regGrant_d   = 1'b1;
                    valid_d      = 1'b1;
                    selector_d   = 1'b1;
                    regCodeOut_d = regCodeOut_q;
                    codeError_d  = codeError_q;
                end
            end

            CTRL_OWN: begin
                if (ctrlRelease) begin
                    state_d        = IDLE;
                    count_d        = 4'd0;
                    lastOwnerReg_d = 1'b0;
                end else begin
                    count_d       = count_q + 4'd1;
                    ctrlGrant_d   = 1'b1;
                    valid_d       = 1'b1;
                    selector_d    = 1'b0;
                    ctrlCodeOut_d = ctrlCodeOut_q;
                    codeError_d   = codeError_q;
                end
            end

            default: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        endcase
    end

    // State, counter and output registers; reset clears everything and makes the register source win the first tie.
    always_ff @(posedge CC_BUS_SCHEDULER_CLOCK_50 or negedge CC_BUS_SCHEDULER_RESET_InLow) begin
        if (!CC_BUS_SCHEDULER_RESET_InLow) begin
            state_q        <= IDLE;
            count_q        <= 4'd0;
            lastOwnerReg_q <= 1'b0;
            regGrant_q     <= 1'b0;
            ctrlGrant_q    <= 1'b0;
            selector_q     <= 1'b0;
            regCodeOut_q   <= '0;
            ctrlCodeOut_q  <= '0;
            valid_q        <= 1'b0;
            codeError_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            lastOwnerReg_q <= lastOwnerReg_d;
            regGrant_q     <= regGrant_d;
            ctrlGrant_q    <= ctrlGrant_d;
            selector_q     <= selector_d;
            regCodeOut_q   <= regCodeOut_d;
            ctrlCodeOut_q  <= ctrlCodeOut_d;
            valid_q        <= valid_d;
            codeError_q    <= codeError_d;
        end
    end

    assign CC_BUS_SCHEDULER_regGrant_Out    = regGrant_q;
    assign CC_BUS_SCHEDULER_ctrlGrant_Out   = ctrlGrant_q;
    assign CC_BUS_SCHEDULER_selector_Out    = selector_q;
    assign CC_BUS_SCHEDULER_registro_OutBUS = regCodeOut_q;
    assign CC_BUS_SCHEDULER_control_OutBUS  = ctrlCodeOut_q;
    assign CC_BUS_SCHEDULER_valid_Out       = valid_q;
    assign CC_BUS_SCHEDULER_codeError_Out   = codeError_q;

endmodule

// File: tb/tb_cc_bus_scheduler.sv
// tb_cc_bus_scheduler: directed and random stimulus for cc_bus_scheduler.
// A transaction-level model predicts the output picture for every driven
// cycle and queues it; an independent monitor pops and compares.

module tb_cc_bus_scheduler;

    localparam int RW = 5;
    localparam int CW = 6;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          regReq = 1'b0;
    logic [RW-1:0] regCode = '0;
    logic          ctrlReq = 1'b0;
    logic [CW-1:0] ctrlCode = '0;
    logic          regGrant;
    logic          ctrlGrant;
    logic          selector;
    logic [RW-1:0] regCodeOut;
    logic [CW-1:0] ctrlCodeOut;
    logic          validOut;
    logic          codeError;

    cc_bus_scheduler #(
        .DATAWIDTH_MUX_SELECTION_REG     (RW),
        .DATAWIDTH_MUX_SELECTION_CONTROL (CW),
        .MAX_BURST                       (MB)
    ) dut (
        .CC_BUS_SCHEDULER_CLOCK_50        (clk),
        .CC_BUS_SCHEDULER_RESET_InLow     (rstN),
        .CC_BUS_SCHEDULER_regReq_In       (regReq),
        .CC_BUS_SCHEDULER_regCode_InBUS   (regCode),
        .CC_BUS_SCHEDULER_ctrlReq_In      (ctrlReq),
        .CC_BUS_SCHEDULER_ctrlCode_InBUS  (ctrlCode),
        .CC_BUS_SCHEDULER_regGrant_Out    (regGrant),
        .CC_BUS_SCHEDULER_ctrlGrant_Out   (ctrlGrant),
        .CC_BUS_SCHEDULER_selector_Out    (selector),
        .CC_BUS_SCHEDULER_registro_OutBUS (regCodeOut),
        .CC_BUS_SCHEDULER_control_OutBUS  (ctrlCodeOut),
        .CC_BUS_SCHEDULER_valid_Out       (validOut),
        .CC_BUS_SCHEDULER_codeError_Out   (codeError)
    );

    always #5 clk = ~clk;

    // Observed output picture: {regGrant, ctrlGrant, selector, valid, codeError, regCode, ctrlCode}
    logic [15:0] dutVec;
    assign dutVec = {regGrant, ctrlGrant, selector, validOut, codeError, regCodeOut, ctrlCodeOut};

    typedef struct {
        int          cyc;
        logic [15:0] vec;
    } exp_t;

    exp_t scoreQ[$];
    int   cycleCount = 0;
    int   compared   = 0;
    int   mismatched = 0;

    // Model: 0 = nobody owns, 1 = register source, 2 = control source.
    int   mOwner;
    int   mUsed;
    int   mLast;
    bit   mSel;
    int   mRCode;
    int   mCCode;

    // Edge counter; the monitor tags each observation with it.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    function automatic logic [15:0] packOut(bit rg, bit cg, bit sel, bit v, bit err, int rc, int cc);
        logic [RW-1:0] rcV;
        logic [CW-1:0] ccV;
        rcV = RW'(rc);
        ccV = CW'(cc);
        return {rg, cg, sel, v, err, rcV, ccV};
    endfunction

    task automatic modelReset();
        mOwner = 0;
        mUsed  = 0;
        mLast  = 2;
        mSel   = 1'b0;
        mRCode = 0;
        mCCode = 0;
    endtask

    // Predicts the picture after the next clock edge from the request rules.
    task automatic modelStep(bit r, int rc, bit c, int cc);
        int   winner;
        bit   stillWants;
        bit   err;
        exp_t e;
        winner = 0;
        if (mOwner == 0) begin
            if (r && c)  winner = (mLast == 2) ? 1 : 2;
            else if (r)  winner = 1;
            else if (c)  winner = 2;
            if (winner != 0) begin
                mOwner = winner;
                mUsed  = 1;
                mSel   = (winner == 1);
                mRCode = (winner == 1) ? rc : 0;
                mCCode = (winner == 2) ? cc : 0;
            end
        end else begin
            stillWants = (mOwner == 1) ? r : c;
            if (!stillWants || mUsed >= MB) begin
                mLast  = mOwner;
                mOwner = 0;
                mUsed  = 0;
            end else begin
                mUsed = mUsed + 1;
            end
        end
        err = (mOwner == 1 && mRCode > 11) || (mOwner == 2 && mCCode > 11);
        e.cyc = cycleCount + 1;
        e.vec = packOut(mOwner == 1, mOwner == 2, mSel, mOwner != 0, err,
                        (mOwner == 1) ? mRCode : 0, (mOwner == 2) ? mCCode : 0);
        scoreQ.push_back(e);
    endtask

    // Drive one cycle of requests, predict its outcome, then step to just after the edge.
    task automatic applyStimulus(bit r, int rc, bit c, int cc);
        int rcT;
        int ccT;
        rcT = rc % (1 << RW);
        ccT = cc % (1 << CW);
        regReq   = r;
        regCode  = RW'(rcT);
        ctrlReq  = c;
        ctrlCode = CW'(ccT);
        modelStep(r, rcT, c, ccT);
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(string name, logic [15:0] want);
        compared++;
        if (dutVec !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, dutVec, want);
        end
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock.
    task automatic pulseReset();
        rstN = 1'b0;
        scoreQ.delete();
        #1;
        checkOutput("async_reset_clear", 16'h0000);
        modelReset();
        #1;
        rstN = 1'b1;
    endtask

    // Monitor: compares each queued prediction at the cycle it was made for.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (scoreQ.size() > 0 && scoreQ[0].cyc < cycleCount) begin
                e = scoreQ.pop_front();
                compared++;
                mismatched++;
                $display("[TB] FAIL missed_cycle: prediction for cycle %0d never observed, now %0d", e.cyc, cycleCount);
            end
            if (scoreQ.size() > 0 && scoreQ[0].cyc == cycleCount) begin
                e = scoreQ.pop_front();
                compared++;
                if (dutVec !== e.vec) begin
                    mismatched++;
                    $display("[TB] FAIL outputs cyc=%0d: got rg=%b cg=%b sel=%b v=%b err=%b rc=%0d cc=%0d, expected rg=%b cg=%b sel=%b v=%b err=%b rc=%0d cc=%0d",
                             cycleCount, dutVec[15], dutVec[14], dutVec[13], dutVec[12], dutVec[11],
                             dutVec[10:6], dutVec[5:0], e.vec[15], e.vec[14], e.vec[13], e.vec[12],
                             e.vec[11], e.vec[10:6], e.vec[5:0]);
                end
            end else if (validOut !== 1'b0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_valid cyc=%0d: got valid=%b, expected 0", cycleCount, validOut);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, compared=%0d", compared);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        modelReset();
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_state", 16'h0000);
        rstN = 1'b1;

        // Single register source, two edges of request.
        applyStimulus(1, 7, 0, 0);
        applyStimulus(1, 7, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0);

        // Tie from reset: alternating bursts separated by idle cycles.
        pulseReset();
        for (int i = 0; i < 14; i++) applyStimulus(1, i, 1, 20 + i);
        repeat (2) applyStimulus(0, 0, 0, 0);

        // Register source alone hits the burst limit and is re-granted with a new code.
        for (int i = 0; i < 11; i++) applyStimulus(1, i + 1, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0);

        // Error code boundaries on the control source.
        repeat (2) applyStimulus(0, 0, 1, 12);
        applyStimulus(0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 1, 11);
        applyStimulus(0, 0, 0, 0);
        repeat (2) applyStimulus(1, 12, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Code stability during ownership.
        applyStimulus(1, 3, 0, 0);
        repeat (2) applyStimulus(1, 9, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0);

        // Reset during control ownership with a register request pending.
        repeat (2) applyStimulus(0, 0, 1, 5);
        regReq  = 1'b1;
        ctrlReq = 1'b0;
        pulseReset();
        repeat (2) applyStimulus(1, 4, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96) pulseReset();
            applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                          $urandom_range(0, 3) != 0, int'($urandom_range(0, 63)));
        end
        repeat (3) applyStimulus(0, 0, 0, 0);

        @(negedge clk);
        #1;
        compared++;
        if (scoreQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", scoreQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cc_bus_scheduler.md
CC_BUS_SCHEDULER -- requirements
Module: cc_bus_scheduler

Interface
REQ-001 Parameter DATAWIDTH_MUX_SELECTION_REG, default 5: width of the register-source code.
REQ-002 Parameter DATAWIDTH_MUX_SELECTION_CONTROL, default 6: width of the control-source code.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive ownership cycles per grant; legal range 1..15.
REQ-004 CC_BUS_SCHEDULER_CLOCK_50  input  1  single clock; all state changes on its rising edge.
REQ-005 CC_BUS_SCHEDULER_RESET_InLow  input  1  reset, asynchronous, active-low.
REQ-006 CC_BUS_SCHEDULER_regReq_In  input  1  register-source bus request.
REQ-007 CC_BUS_SCHEDULER_regCode_InBUS  input  DATAWIDTH_MUX_SELECTION_REG  register-source code.
REQ-008 CC_BUS_SCHEDULER_ctrlReq_In  input  1  control-source bus request.
REQ-009 CC_BUS_SCHEDULER_ctrlCode_InBUS  input  DATAWIDTH_MUX_SELECTION_CONTROL  control-source code.
REQ-010 CC_BUS_SCHEDULER_regGrant_Out  output  1  register source owns the bus.
REQ-011 CC_BUS_SCHEDULER_ctrlGrant_Out  output  1  control source owns the bus.
REQ-012 CC_BUS_SCHEDULER_selector_Out  output  1  bus-mux selector; 1 = register source, 0 = control source.
REQ-013 CC_BUS_SCHEDULER_registro_OutBUS  output  DATAWIDTH_MUX_SELECTION_REG  latched register code to the bus mux.
REQ-014 CC_BUS_SCHEDULER_control_OutBUS  output  DATAWIDTH_MUX_SELECTION_CONTROL  latched control code to the bus mux.
REQ-015 CC_BUS_SCHEDULER_valid_Out  output  1  bus transfer in progress.
REQ-016 CC_BUS_SCHEDULER_codeError_Out  output  1  latched code outside the legal 0..11 range.

Function
REQ-017 All outputs SHALL be registered; states: IDLE, REG_OWN, CTRL_OWN.
REQ-018 IDLE: grants 0, valid 0, codeError 0, both code buses 0, selector holds its last value.
REQ-019 IDLE arbitration at each edge: only regReq -> REG_OWN; only ctrlReq -> CTRL_OWN; both -> the source not recorded in last_owner; neither -> stay IDLE.
REQ-020 On entry to REG_OWN (same edge): regGrant=1, valid=1, selector=1, registro_OutBUS=regCode_InBUS sampled on that edge, control_OutBUS=0, burst count=1.
REQ-021 On entry to CTRL_OWN (same edge): ctrlGrant=1, valid=1, selector=0, control_OutBUS=ctrlCode_InBUS sampled on that edge, registro_OutBUS=0, burst count=1.
REQ-022 The latched code SHALL be held for the whole ownership; code-input changes during ownership are ignored.
REQ-023 At each edge in X_OWN: if the owner's req=0 or count==MAX_BURST -> IDLE, last_owner=X; else count+1 and stay.
REQ-024 Request-to-grant latency: one edge; valid lasts at most MAX_BURST cycles per grant.
REQ-025 At least one IDLE cycle (grants and valid 0) SHALL separate any two ownerships, including re-grant of the same source.
REQ-026 A non-owner request during ownership SHALL wait; it is considered only at the next IDLE arbitration.
REQ-027 codeError_Out SHALL be 1 during ownership iff the latched code is greater than 11 (decimal); valid stays 1.
REQ-028 regGrant and ctrlGrant SHALL never both be 1.
REQ-029 The burst counter SHALL be 4 bits wide and SHALL never exceed MAX_BURST.

Reset
REQ-030 RESET_InLow=0 SHALL immediately, without a clock edge, force: state IDLE, all outputs 0, selector 0, count 0, last_owner=CTRL (the register source wins the first tie).
REQ-031 Reset mid-ownership SHALL abort the transfer with no further valid cycle; after release, arbitration resumes from IDLE on the next edge.

Verification
REQ-032 Single source: regReq=1 with regCode=5'd7 for 2 edges, then 0 -> regGrant, valid and selector=1 for 2 cycles, registro_OutBUS=7, then IDLE.
REQ-033 Tie after reset: both reqs held high, MAX_BURST=4 -> REG owns 4 cycles, 1 IDLE cycle, CTRL owns 4 cycles, 1 IDLE cycle, REG again; grants never overlap.
REQ-034 Burst limit: regReq held continuously alone -> 4 valid cycles, 1 IDLE cycle, re-grant with a newly sampled code.
REQ-035 Error code: ctrlReq with ctrlCode=6'd12 -> ctrlGrant=1, valid=1, codeError=1, selector=0; with 6'd11 -> codeError=0.
REQ-036 Code stability: regCode changed from 3 to 9 mid-ownership -> registro_OutBUS stays 3 until release.
REQ-037 Async reset: RESET_InLow pulsed low between edges during CTRL_OWN -> all outputs 0 immediately; a pending regReq is granted one edge after reset release.
